// File: rtl/iterative_divider_pkg.sv
// Shared divider types: state encoding, ALU-width constants, port bundles.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package iterative_divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_MSB   = DIV_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_div_e;

  // Port bundles at ALU width, mirroring the ALU's request/response structs.
  typedef struct packed {
    logic               signed_op;
    logic [DIV_MSB:0]   a;
    logic [DIV_MSB:0]   b;
  } port_in_divider_t;

  typedef struct packed {
    logic [DIV_MSB:0]   quot;
    logic [DIV_MSB:0]   rem;
    logic               div_zero;
  } port_out_divider_t;

endpackage

// File: rtl/iterative_divider_div_step.sv
// One radix-2 restoring division step (purely combinational).
// Latency: 0 cycles. Backpressure: none, iterated by the parent FSM.
// Ports: rem_in/quot_in partial state, divisor; rem_out/quot_out next state.
module iterative_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quot_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;

  // Shift the next dividend bit (quotient MSB) into the partial remainder.
  assign shifted = {rem_in, quot_in[WIDTH-1]};

  // WIDTH+1-bit subtract on the low WIDTH bits; trial[WIDTH] is the borrow.
  // A set shifted[WIDTH] means the shifted remainder exceeds any divisor,
  // and the low-bit difference is then still exact since the true result
  // is below the divisor.
  assign trial = {1'b0, shifted[WIDTH-1:0]} - {1'b0, divisor};
  assign fits  = shifted[WIDTH] | ~trial[WIDTH];

  assign rem_out  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_out = {quot_in[WIDTH-2:0], fits};

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed/unsigned restoring divider beside the execute-stage ALU.
// Latency: accept at edge N -> out_valid after edge N+WIDTH+2, data-independent.
// Backpressure: in_ready only in IDLE; result held while out_valid && !out_ready.
// Ports: clk, rst (async high), flush (sync abort); in_valid/in_ready/in_signed/
//   in_a/in_b request side; out_valid/out_ready/out_quot/out_rem/out_div_zero
//   response side.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div_zero
);

  state_div_e           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     rem_q, quot_q, dvsr_q;
  logic [WIDTH-1:0]     rem_nxt, quot_nxt;
  logic                 q_neg, r_neg, dz_q;
  logic                 accept;

  // Magnitude of 0x80..0 stays 0x80..0, which is correct read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_valid;

  iterative_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem_q),
    .quot_in  (quot_q),
    .divisor  (dvsr_q),
    .rem_out  (rem_nxt),
    .quot_out (quot_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)               state_nxt = CALC;
        CALC:    if (cnt == '0)              state_nxt = FIXUP;
        FIXUP:                               state_nxt = DONE;
        DONE:    if (out_valid && out_ready) state_nxt = IDLE;
        default:                             state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      dvsr_q       <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dz_q         <= 1'b0;
      out_valid    <= 1'b0;
      out_quot     <= '0;
      out_rem      <= '0;
      out_div_zero <= 1'b0;
    end else if (flush) begin
      cnt          <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      dvsr_q       <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dz_q         <= 1'b0;
      out_valid    <= 1'b0;
      out_quot     <= '0;
      out_rem      <= '0;
      out_div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Dividend sits in the quotient register and shifts out MSB-first.
            rem_q  <= '0;
            quot_q <= mag(in_a, in_signed);
            dvsr_q <= mag(in_b, in_signed);
            q_neg  <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            r_neg  <= in_signed & in_a[WIDTH-1];
            dz_q   <= (in_b == '0);
            cnt    <= CNT_WIDTH'(WIDTH - 1);
          end
        end
        CALC: begin
          rem_q  <= rem_nxt;
          quot_q <= quot_nxt;
          cnt    <= cnt - 1'b1;
        end
        FIXUP: begin
          // With a zero divisor every trial "fits", so the remainder is |a|
          // and the sign fixup restores the original dividend; only the
          // quotient needs forcing to all ones.
          out_quot     <= dz_q ? '1 : (q_neg ? (~quot_q + 1'b1) : quot_q);
          out_rem      <= r_neg ? (~rem_q + 1'b1) : rem_q;
          out_div_zero <= dz_q;
        end
        DONE: begin
          // Result registers settle in the first DONE cycle; out_valid then
          // comes straight from a flop, giving the fixed WIDTH+2 latency.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed-vector bench for iterative_divider with hand-computed results.
// Latency: checks out_valid low through edge N+33 and high after edge N+34.
// Backpressure: holds out_ready low, checks stability, then back-to-back accept.
module tb_iterative_divider;
  import iterative_divider_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quot;
  logic [W-1:0] out_rem;
  logic         out_div_zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string             name;
    logic              s;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    port_out_divider_t e;
  } vec_t;

  vec_t vecs[$];

  iterative_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_signed    (in_signed),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quot     (out_quot),
    .out_rem      (out_rem),
    .out_div_zero (out_div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic [W-1:0] r, input logic dz);
    vec_t v;
    v.name = name;
    v.s = s;
    v.a = a;
    v.b = b;
    v.e.quot = q;
    v.e.rem = r;
    v.e.div_zero = dz;
    vecs.push_back(v);
  endtask

  // Present operands for one edge, then scramble them so any late sampling
  // of the inputs would corrupt the result.
  task automatic launch(input string tag, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    chk({tag, " in_ready before accept"}, in_ready, 1);
    in_signed = s;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_signed = ~s;
    in_a      = ~a;
    in_b      = '0;
  endtask

  task automatic wait_result(input string tag, input port_out_divider_t e);
    int bad;
    bad = 0;
    for (int k = 1; k <= W + 1; k++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    chk({tag, " quiet cycles"}, bad, 0);
    tick();
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " quot"}, out_quot, e.quot);
    chk({tag, " rem"}, out_rem, e.rem);
    chk({tag, " div_zero"}, out_div_zero, e.div_zero);
  endtask

  task automatic drain(input string tag);
    tick();
    chk({tag, " out_valid after handshake"}, out_valid, 0);
    chk({tag, " in_ready after handshake"}, in_ready, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    port_out_divider_t e;
    int bad;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;

    add_vec("u100/7",    0, 32'd100,        32'd7,          32'd14,         32'd2,          0);
    add_vec("s-7/2",     1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   0);
    add_vec("s7/-2",     1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          0);
    add_vec("u/zero",    0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1);
    add_vec("s-7/zero",  1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1);
    add_vec("s_ovf",     1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0);
    add_vec("umax/1",    0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          0);
    add_vec("u8000/max", 0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   0);
    add_vec("s-100/-7",  1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   0);
    add_vec("u5/9",      0, 32'd5,          32'd9,          32'd0,          32'd5,          0);
    add_vec("umax/16",   0, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF,   32'd15,         0);

    // Reset state while rst is held.
    #12;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_quot", out_quot, 0);
    chk("reset out_rem", out_rem, 0);
    chk("reset out_div_zero", out_div_zero, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      launch(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b);
      wait_result(vecs[i].name, vecs[i].e);
      drain(vecs[i].name);
    end

    // Async reset mid-CALC: outputs (still holding the last result) clear
    // without a clock edge.
    launch("rst_mid", 1'b1, 32'hFFFFFFF9, 32'd2);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid in_ready", in_ready, 1);
    chk("rst_mid out_valid", out_valid, 0);
    chk("rst_mid out_quot", out_quot, 0);
    chk("rst_mid out_rem", out_rem, 0);
    chk("rst_mid out_div_zero", out_div_zero, 0);
    #1;
    rst = 1'b0;
    tick();
    e.quot = 32'd6; e.rem = 32'd2; e.div_zero = 1'b0;
    launch("post_rst 20/3", 1'b0, 32'd20, 32'd3);
    wait_result("post_rst 20/3", e);
    drain("post_rst 20/3");

    // Backpressure: result held for 10 cycles while a new request waits.
    out_ready = 1'b0;
    e.quot = 32'd14; e.rem = 32'd2; e.div_zero = 1'b0;
    launch("bp 100/7", 1'b0, 32'd100, 32'd7);
    wait_result("bp 100/7", e);
    in_signed = 1'b0; in_a = 32'd20; in_b = 32'd3; in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quot !== 32'd14 ||
          out_rem !== 32'd2 || out_div_zero !== 1'b0) bad++;
    end
    chk("bp hold stable", bad, 0);
    out_ready = 1'b1;
    tick();
    chk("bp out_valid after release", out_valid, 0);
    e.quot = 32'd6; e.rem = 32'd2; e.div_zero = 1'b0;
    launch("bp b2b 20/3", 1'b0, 32'd20, 32'd3);
    wait_result("bp b2b 20/3", e);
    drain("bp b2b 20/3");

    // Flush at cycle 10 of CALC: back to IDLE, results cleared, never valid.
    launch("flush", 1'b0, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush in_ready", in_ready, 1);
    chk("flush out_valid", out_valid, 0);
    chk("flush out_quot cleared", out_quot, 0);
    chk("flush out_rem cleared", out_rem, 0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("flush no late valid", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
